// File: rtl/arr_host_pkg.sv
// arr_host_pkg: shared types for the kernel array host driver.
// Holds the FSM state enum and default sizing parameters.
package arr_host_pkg;

    localparam int DEFAULT_DEPTH  = 1000;
    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DUMP_ADDR,
        DUMP_DATA,
        FINISH
    } state_t;

endpackage

// File: rtl/arr_host_rdbuf.sv
// arr_host_rdbuf: one-entry readback holding register (valid/ready + last).
// Ports: clk, rst; in_valid/in_data/in_last from the array; out_* downstream.
module arr_host_rdbuf
    import arr_host_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic              full_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // First dump cycle passes the array read data straight through; if it
    // is not taken, it is captured and held until the consumer accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (!in_valid || out_ready) begin
            full_q <= 1'b0;
        end else if (!full_q) begin
            full_q <= 1'b1;
            data_q <= in_data;
            last_q <= in_last;
        end
    end

    assign out_valid = in_valid;
    assign out_data  = full_q ? data_q : (in_valid ? in_data : '0);
    assign out_last  = full_q ? last_q : (in_valid & in_last);

endmodule

// File: rtl/arr_host_driver.sv
// arr_host_driver: loads a kernel array, starts the kernel, dumps the array.
// Ports: go/init_*, in_* load stream, out_* readback stream, status, k_* kernel side.
// Optional watchdog enabled by defining ARR_HOST_TIMEOUT_EN.
module arr_host_driver
    import arr_host_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] init_i,
    input  logic [DATA_W-1:0] init_acc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic              timeout,
    output logic              k_r_enable,
    output logic [ADDR_W-1:0] k_init_i_t_a,
    output logic [DATA_W-1:0] k_init_acc_t_a,
    input  logic              k_w_enable,
    input  logic              k_result,
    output logic              k_controlArr,
    output logic              k_controlArrWEnable_a,
    output logic [ADDR_W-1:0] k_controlArrAddr_a,
    output logic [DATA_W-1:0] k_controlArrWData_a,
    input  logic [DATA_W-1:0] k_controlArrRData_a
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] init_i_q;
    logic [DATA_W-1:0] init_acc_q;
    logic              result_q;
    logic              armed_q;
    logic              at_last, load_acc, dump_acc, k_done;
    logic              tmo_hit, dump_valid;

    assign at_last  = (addr_q == LAST_ADDR);
    assign load_acc = (state_q == LOAD) && in_valid;
    assign dump_acc = (state_q == DUMP_DATA) && out_ready;
    // k_w_enable is still high from the previous job in the first RUN cycle.
    assign k_done   = (state_q == RUN) && armed_q && k_w_enable;

`ifdef ARR_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    assign tmo_hit = (state_q == RUN) && !k_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == START)
                cnt_q <= '0;
            else if (state_q == RUN)
                cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == IDLE && go)
                timeout_q <= 1'b0;
            else if (tmo_hit)
                timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (go) state_d = LOAD;
            LOAD:      if (load_acc && at_last) state_d = START;
            START:     state_d = RUN;
            RUN: begin
                if (k_done)
                    state_d = DUMP_ADDR;
                else if (tmo_hit)
                    state_d = FINISH;
            end
            DUMP_ADDR: state_d = DUMP_DATA;
            DUMP_DATA: if (dump_acc) state_d = at_last ? FINISH : DUMP_ADDR;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready              = 1'b0;
        k_controlArr          = 1'b0;
        k_controlArrWEnable_a = 1'b0;
        k_controlArrAddr_a    = '0;
        k_controlArrWData_a   = '0;
        k_r_enable            = 1'b0;
        dump_valid            = 1'b0;
        done                  = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready              = 1'b1;
                k_controlArr          = 1'b1;
                k_controlArrWEnable_a = in_valid;
                k_controlArrAddr_a    = addr_q;
                k_controlArrWData_a   = in_valid ? in_data : '0;
            end
            START: k_r_enable = 1'b1;
            DUMP_ADDR: begin
                k_controlArr       = 1'b1;
                k_controlArrAddr_a = addr_q;
            end
            DUMP_DATA: begin
                k_controlArr       = 1'b1;
                k_controlArrAddr_a = addr_q;
                dump_valid         = 1'b1;
            end
            FINISH: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            init_i_q   <= '0;
            init_acc_q <= '0;
            result_q   <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        addr_q     <= '0;
                        init_i_q   <= init_i;
                        init_acc_q <= init_acc;
                    end
                end
                LOAD: begin
                    if (load_acc)
                        addr_q <= at_last ? '0 : addr_q + ADDR_W'(1);
                end
                START: armed_q <= 1'b0;
                RUN: begin
                    armed_q <= 1'b1;
                    if (k_done)
                        result_q <= k_result;
                    else if (tmo_hit)
                        result_q <= 1'b0;
                end
                DUMP_DATA: begin
                    if (dump_acc && !at_last)
                        addr_q <= addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign result         = result_q;
    assign k_init_i_t_a   = init_i_q;
    assign k_init_acc_t_a = init_acc_q;

    arr_host_rdbuf #(
        .DATA_W(DATA_W)
    ) u_rdbuf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (dump_valid),
        .in_data  (k_controlArrRData_a),
        .in_last  (at_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last)
    );

endmodule

// File: doc/arr_host_driver.md
Name: arr_host_driver

Overview:
- Host-side initiator for a generated kernel that owns one on-chip array and exposes it through a controlArr side port.
- Phase 1: streams DEPTH input words into the kernel array through the control port.
- Phase 2: pulses the kernel start input, then waits for kernel completion.
- Phase 3: reads the whole array back out as a valid/ready stream and reports the kernel's 1-bit result.

Parameters:
- DEPTH, 1000: number of array words loaded and dumped.
- ADDR_W, 10: array address width; DEPTH <= 2**ADDR_W.
- DATA_W, 64: array word width (signed).
- TIMEOUT_CYCLES, 1048576: watchdog limit, used only when the optional feature is enabled.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  one-cycle pulse; starts a job when in IDLE.
- init_i  in  ADDR_W  initial index forwarded to the kernel.
- init_acc  in  DATA_W  initial accumulator forwarded to the kernel.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream word accepted.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  readback word valid.
- out_ready  in  1  downstream accepts the readback word.
- out_data  out  DATA_W  readback word.
- out_last  out  1  marks the readback word at address DEPTH-1.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a job ends.
- result  out  1  kernel result, latched at kernel completion.
- timeout  out  1  job aborted by watchdog; 0 when the feature is off.
- k_r_enable  out  1  kernel start/load input.
- k_init_i_t_a  out  ADDR_W  kernel initial index.
- k_init_acc_t_a  out  DATA_W  kernel initial accumulator.
- k_w_enable  in  1  kernel finished; level, held until the next start.
- k_result  in  1  kernel result.
- k_controlArr  out  1  control-port ownership of the kernel array.
- k_controlArrWEnable_a  out  1  control-port write enable.
- k_controlArrAddr_a  out  ADDR_W  control-port address.
- k_controlArrWData_a  out  DATA_W  control-port write data.
- k_controlArrRData_a  in  DATA_W  control-port read data.

Behaviour:
- Reset (rst=1 at posedge, from any state, including mid-job):
  - FSM goes to IDLE; address counter cleared.
  - All outputs 0, including k_controlArr and k_r_enable.
  - Partial array contents are not restored.
- Kernel array read timing: read data is valid the cycle after the address is presented with write enable 0. A read in the same cycle as a write returns undefined data, so the driver never writes during a read.
- IDLE:
  - in_ready=0, out_valid=0, k_controlArr=0.
  - On go: latch init_i and init_acc into k_init_* (held stable until the next job), clear addr, go to LOAD.
  - go is ignored while busy.
- LOAD:
  - k_controlArr=1 and in_ready=1.
  - On in_valid&&in_ready: WEnable=1, Addr=addr, WData=in_data, addr increments.
  - When the word at DEPTH-1 is accepted: addr cleared, go to START.
  - in_valid low stalls with no write.
- START (1 cycle):
  - k_controlArr=0, k_r_enable=1; the kernel loads init_*.
  - Next state is RUN.
- RUN:
  - k_controlArr=0, k_r_enable=0.
  - k_w_enable is ignored in the first RUN cycle, because it is a stale level from the previous job.
  - From the second RUN cycle on, k_w_enable=1 latches result<=k_result and moves to DUMP_ADDR.
- DUMP_ADDR:
  - k_controlArr=1, WEnable=0, Addr=addr.
  - Next state is DUMP_DATA.
- DUMP_DATA:
  - out_data is captured from RData on entry; out_valid=1; out_last=(addr==DEPTH-1).
  - Captured data and address are held while out_ready=0.
  - On out_ready: if last, go to FINISH; otherwise addr increments and the FSM returns to DUMP_ADDR.
  - Maximum readback rate is one word per 2 cycles.
- FINISH (1 cycle):
  - done=1, k_controlArr=0.
  - Next state is IDLE.
- Address counter:
  - ADDR_W bits; never wraps past DEPTH-1.
  - DEPTH=1 is a legal configuration: a single load, then a single dump word with out_last=1.
- Simultaneous go and rst: rst wins.

Optional Feature:
- Macro: ARR_HOST_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entry to RUN.
  - If it reaches TIMEOUT_CYCLES before k_w_enable: timeout<=1, result<=0, skip the dump, go to FINISH (done pulses).
  - timeout is cleared on the next go.
- Disabled: no counter; timeout is tied to 0; RUN waits indefinitely.

Decomposition:
- Package arr_host_pkg holds:
  - the state enum: IDLE, LOAD, START, RUN, DUMP_ADDR, DUMP_DATA, FINISH;
  - DEFAULT_DEPTH, DEFAULT_ADDR_W, DEFAULT_DATA_W.
- Sub-module arr_host_rdbuf: the one-entry output holding register with valid/ready and last. Everything else stays in the top FSM.

Test Plan:
- Nominal job: DEPTH=4, words 10,20,30,40, init_i=0, init_acc=0, kernel model returns the array unchanged and result=1 after 5 RUN cycles.
  - Required: 4 writes at addresses 0..3; exactly one k_r_enable pulse.
  - Required: out stream 10,20,30,40 with out_last only on 40; result=1; one done pulse.
- Backpressure: as above with out_ready low for 3 cycles on word 2.
  - Required: out_data stays at 20; no address advance.
  - Required: no control-port write at any time during DUMP.
- Input stalls: in_valid toggles every other cycle.
  - Required: exactly 4 writes, addresses 0,1,2,3 in order; START entered only after the 4th accept.
- Stale completion: k_w_enable held 1 from the previous job.
  - Required: the FSM spends at least 2 cycles in RUN and leaves only when the model asserts k_w_enable for the current job; no early dump.
- Reset mid-DUMP: rst asserted while out_valid=1.
  - Required: next cycle all outputs 0 and busy=0.
  - Required: a new go runs a full job correctly.
- With ARR_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, kernel never finishes.
  - Required: timeout=1 on the 16th RUN cycle; done pulses; no out_valid.
  - Required: the next go clears timeout.
